data_mem_ctrl: RTL and testbench

Data-memory access controller on the load/store path of the RV32I core. It consumes the decoder's memory controls (DMWr, DMCtrl), the ALU-computed byte address and the rs2 store data. It drives a word-wide synchronous SRAM port with byte enables and returns sign- or zero-extended load data. Accesses that cross a word boundary are split into two SRAM transactions by a small FSM, under a valid/ready handshake to the core.

---
 rtl/dm_pkg.sv | 27 ++
 rtl/dm_lane_align.sv | 52 +++++
 rtl/data_mem_ctrl.sv | 151 +++++++++++++++
 tb/tb_data_mem_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared load/store encodings and controller state for the RV32I data-memory path.
// The decoder and data_mem_ctrl both import this package.
package dm_pkg;

  localparam logic [2:0] DM_B  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_W  = 3'b010;
  localparam logic [2:0] DM_BU = 3'b100;
  localparam logic [2:0] DM_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC0   = 2'd1,
    ACC1   = 2'd2,
    FINISH = 2'd3
  } dm_state_e;

  // Access size in bytes; bit 2 (unsigned) never affects size, and 011/11x act as W.
  function automatic logic [2:0] dm_size(input logic [2:0] ctrl);
    case (ctrl[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Combinational lane steering: store data/byte-enable placement across two words
// and load extraction with sign/zero extension.
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [2:0]  ctrl,
  input  logic [1:0]  off,
  input  logic [31:0] store_data,
  input  logic [31:0] lo_word,
  input  logic [31:0] hi_word,
  output logic        split,
  output logic [3:0]  be0,
  output logic [3:0]  be1,
  output logic [31:0] lane0,
  output logic [31:0] lane1,
  output logic [31:0] load_data
);

  logic [2:0]  size;
  logic [7:0]  mask;
  logic [63:0] lanes;
  logic [31:0] shifted;

  assign size  = dm_size(ctrl);
  assign split = ({1'b0, off} + size) > 3'd4;

  always_comb begin
    case (size)
      3'd1:    mask = 8'h01;
      3'd2:    mask = 8'h03;
      default: mask = 8'h0F;
    endcase
    mask  = mask << off;
    lanes = {32'b0, store_data} << {off, 3'b000};
    be0   = mask[3:0];
    be1   = mask[7:4];
    lane0 = lanes[31:0];
    lane1 = lanes[63:32];
  end

  always_comb begin
    shifted = 32'({hi_word, lo_word} >> {off, 3'b000});
    case (ctrl)
      DM_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      DM_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      DM_BU:   load_data = {24'b0, shifted[7:0]};
      DM_HU:   load_data = {16'b0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store controller: drives a word-wide synchronous SRAM with byte enables,
// splitting word-crossing accesses into two SRAM transactions.
module data_mem_ctrl
  import dm_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  output logic              ready,
  input  logic              DMWr,
  input  logic [2:0]        DMCtrl,
  input  logic [31:0]       Addr,
  input  logic [31:0]       DataWr,
  output logic [31:0]       DataRd,
  output logic              done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  dm_state_e          state_q, state_d;
  logic               dmwr_q, dmwr_d;
  logic [2:0]         ctrl_q, ctrl_d;
  logic [1:0]         off_q, off_d;
  logic [ADDR_W-1:0]  w0_q, w0_d, w1;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        lo_q, lo_d;
  logic [31:0]        data_rd_q, data_rd_d;
  logic               done_q, done_d;

  logic               split;
  logic [3:0]         be0, be1;
  logic [31:0]        lane0, lane1, load_word, lo_word;
  logic               unused_addr_hi;

  assign unused_addr_hi = ^Addr[31:ADDR_W+2];
  assign w1      = w0_q + ADDR_W'(1);
  // A non-split load finds its only word on mem_rdata during FINISH.
  assign lo_word = split ? lo_q : mem_rdata;

  dm_lane_align u_align (
    .ctrl       (ctrl_q),
    .off        (off_q),
    .store_data (wdata_q),
    .lo_word    (lo_word),
    .hi_word    (mem_rdata),
    .split      (split),
    .be0        (be0),
    .be1        (be1),
    .lane0      (lane0),
    .lane1      (lane1),
    .load_data  (load_word)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = ACC0;
      ACC0:    state_d = split ? ACC1 : FINISH;
      ACC1:    state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    // NOTE: hold-value defaults on every comb output keep this block latch-free.
    dmwr_d    = dmwr_q;
    ctrl_d    = ctrl_q;
    off_d     = off_q;
    w0_d      = w0_q;
    wdata_d   = wdata_q;
    lo_d      = lo_q;
    data_rd_d = data_rd_q;
    done_d    = (state_q == FINISH);
    if (state_q == IDLE && req) begin
      dmwr_d  = DMWr;
      ctrl_d  = DMCtrl;
      off_d   = Addr[1:0];
      w0_d    = Addr[ADDR_W+1:2];
      wdata_d = DataWr;
    end
    if (state_q == ACC1) lo_d = mem_rdata;
    if (state_q == FINISH && !dmwr_q) data_rd_d = load_word;
  end

  // NOTE: reset is synchronous, so it is sampled inside the clocked block only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dmwr_q    <= 1'b0;
      ctrl_q    <= 3'b0;
      off_q     <= 2'b0;
      w0_q      <= '0;
      wdata_q   <= 32'b0;
      lo_q      <= 32'b0;
      data_rd_q <= 32'b0;
      done_q    <= 1'b0;
    end else begin
      dmwr_q    <= dmwr_d;
      ctrl_q    <= ctrl_d;
      off_q     <= off_d;
      w0_q      <= w0_d;
      wdata_q   <= wdata_d;
      lo_q      <= lo_d;
      data_rd_q <= data_rd_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    ready     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0;
    mem_addr  = '0;
    mem_wdata = 32'b0;
    case (state_q)
      IDLE: ready = 1'b1;
      ACC0: begin
        mem_en    = 1'b1;
        mem_we    = dmwr_q;
        mem_be    = dmwr_q ? be0 : 4'hF;
        mem_addr  = w0_q;
        mem_wdata = lane0;
      end
      ACC1: begin
        mem_en    = 1'b1;
        mem_we    = dmwr_q;
        mem_be    = be1;
        mem_addr  = w1;
        mem_wdata = lane1;
      end
      default: ;
    endcase
  end

  assign DataRd = data_rd_q;
  assign done   = done_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: directed loads/stores with hand-computed
// SRAM transactions, load results and completion cycles.
module tb_data_mem_ctrl;
  import dm_pkg::*;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req;
  logic              ready;
  logic              DMWr;
  logic [2:0]        DMCtrl;
  logic [31:0]       Addr;
  logic [31:0]       DataWr;
  logic [31:0]       DataRd;
  logic              done;
  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  data_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .ready     (ready),
    .DMWr      (DMWr),
    .DMCtrl    (DMCtrl),
    .Addr      (Addr),
    .DataWr    (DataWr),
    .DataRd    (DataRd),
    .done      (done),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM with one-cycle read latency.
  logic [31:0] sram [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int i = 0; i < 4; i++)
          if (mem_be[i]) sram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
  } acc_t;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } done_t;

  acc_t  acc_q[$];
  done_t done_q[$];
  int    total = 0;
  int    bad   = 0;
  logic [31:0] last_rd = 32'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Monitor: compares every SRAM access and every done pulse against the scoreboard.
  always @(negedge clk) begin
    if (mem_en) begin
      check("acc_expected", 32'(acc_q.size() != 0), 32'd1);
      if (acc_q.size() != 0) begin
        acc_t e;
        e = acc_q.pop_front();
        check("acc_we", 32'(mem_we), 32'(e.we));
        check("acc_addr", 32'(mem_addr), 32'(e.addr));
        check("acc_be", 32'(mem_be), 32'(e.be));
        if (e.we) check("acc_wdata", mem_wdata & be_mask(e.be), e.wdata);
      end
    end
    if (done) begin
      check("done_expected", 32'(done_q.size() != 0), 32'd1);
      if (done_q.size() != 0) begin
        done_t d;
        d = done_q.pop_front();
        check("done_data", DataRd, d.data);
        check("done_cycle", 32'(cyc), 32'(d.cyc));
      end
    end
  end

  task automatic acc(input logic we, input int addr, input logic [3:0] be, input logic [31:0] wd);
    acc_t e;
    e.we = we; e.addr = ADDR_W'(addr); e.be = be; e.wdata = wd;
    acc_q.push_back(e);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", 32'(ready), 32'd1);
  endtask

  // Issue one request; 'garble' holds req high with junk inputs while busy.
  task automatic do_req(input logic wr, input logic [2:0] ctrl, input logic [31:0] addr,
                        input logic [31:0] wd, input logic split, input logic [31:0] rd_exp,
                        input logic garble);
    done_t d;
    wait_ready();
    d.data = wr ? last_rd : rd_exp;
    d.cyc  = cyc + (split ? 4 : 3);
    done_q.push_back(d);
    if (!wr) last_rd = rd_exp;
    req = 1'b1; DMWr = wr; DMCtrl = ctrl; Addr = addr; DataWr = wd;
    @(negedge clk);
    if (garble) begin
      DMWr = ~wr; Addr = 32'h0000_03FC; DataWr = 32'hFFFF_FFFF;
      @(negedge clk);
    end
    req = 1'b0; DMWr = 1'b0; DMCtrl = DM_W; Addr = 32'b0; DataWr = 32'b0;
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; DMWr = 1'b0; DMCtrl = DM_W; Addr = 32'b0; DataWr = 32'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_datard", DataRd, 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    acc(1, 4, 4'hF, 32'hDEAD_BEEF);      do_req(1, DM_W,  32'h10, 32'hDEAD_BEEF, 0, 0, 1);
    acc(1, 4, 4'hF, 32'h80AA_BBCC);      do_req(1, DM_W,  32'h10, 32'h80AA_BBCC, 0, 0, 0);
    acc(0, 4, 4'hF, 0);                  do_req(0, DM_B,  32'h13, 0, 0, 32'hFFFF_FF80, 0);
    acc(0, 4, 4'hF, 0);                  do_req(0, DM_BU, 32'h13, 0, 0, 32'h0000_0080, 0);
    acc(0, 4, 4'hF, 0);                  do_req(0, DM_H,  32'h12, 0, 0, 32'hFFFF_80AA, 0);
    acc(1, 3, 4'hF, 32'h4433_2211);      do_req(1, DM_W,  32'h0C, 32'h4433_2211, 0, 0, 0);
    acc(1, 4, 4'hF, 32'h8877_6655);      do_req(1, DM_W,  32'h10, 32'h8877_6655, 0, 0, 0);
    acc(0, 3, 4'hF, 0); acc(0, 4, 4'h3, 0);
    do_req(0, DM_W, 32'h0E, 0, 1, 32'h6655_4433, 0);
    acc(1, 3, 4'h8, 32'hB200_0000); acc(1, 4, 4'h1, 32'h0000_00A1);
    do_req(1, DM_H, 32'h0F, 32'h0000_A1B2, 1, 0, 0);
    acc(0, 3, 4'hF, 0); acc(0, 4, 4'h1, 0);
    do_req(0, DM_HU, 32'h0F, 0, 1, 32'h0000_A1B2, 0);
    acc(0, 4, 4'hF, 0);                  do_req(0, 3'b111, 32'h10, 0, 0, 32'h8877_66A1, 0);
    acc(1, 1023, 4'hF, 32'h1111_2222);   do_req(1, DM_W,  32'hFFC, 32'h1111_2222, 0, 0, 0);
    acc(1, 0, 4'hF, 32'h3333_4444);      do_req(1, DM_W,  32'h000, 32'h3333_4444, 0, 0, 0);
    acc(0, 1023, 4'hF, 0); acc(0, 0, 4'h3, 0);
    do_req(0, DM_W, 32'hFFE, 0, 1, 32'h4444_1111, 0);
    acc(0, 0, 4'hF, 0);                  do_req(0, DM_B,  32'hFFFF_F001, 0, 0, 32'h0000_0044, 0);
    acc(1, 1, 4'h3, 32'h0000_9C05);      do_req(1, DM_HU, 32'h04, 32'h1234_9C05, 0, 0, 0);
    acc(0, 1, 4'hF, 0);                  do_req(0, DM_H,  32'h04, 0, 0, 32'hFFFF_9C05, 0);

    // Reset asserted while the split load sits in ACC1.
    wait_ready();
    acc(0, 3, 4'hF, 0); acc(0, 4, 4'h3, 0);
    req = 1'b1; DMWr = 1'b0; DMCtrl = DM_W; Addr = 32'h0E;
    @(negedge clk);
    req = 1'b0; Addr = 32'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_mem_en", 32'(mem_en), 32'd0);
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_datard", DataRd, 32'd0);
    rst_n = 1'b1;
    last_rd = 32'b0;
    @(negedge clk);
    acc(0, 4, 4'hF, 0);                  do_req(0, DM_W,  32'h10, 0, 0, 32'h8877_66A1, 0);

    wait_ready();
    repeat (4) @(negedge clk);
    check("acc_queue_empty", 32'(acc_q.size()), 32'd0);
    check("done_queue_empty", 32'(done_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
